// File: rtl/cpu_load_scoreboard.sv
// rtl/cpu_load_scoreboard.sv - load scoreboard that gates ID issue on registers owed by outstanding loads
//
// Tracks destination registers of in-flight long-latency loads. Holds the ID
// stage on RAW/WAW hazards against them, bounds the number of loads in flight,
// and sequences a drain (fence) handshake.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   id_valid                     valid instruction in ID
//   id_ra/id_rb, *_used          source indices and whether each is read
//   id_rd, id_writeback          destination index and whether it is written
//   id_is_load                   instruction is a long-latency load
//   flush                        kill the ID instruction this cycle
//   ld_done, ld_rd               load response and its destination register
//   drain_req                    level request: stop issue and empty loads
//   stall_id, id_fire            combinational issue gating
//   pending_cnt                  outstanding load count
//   drained                      drain complete (registered)
//   err_spurious                 sticky: response for a non-pending register
//   stall_cycles                 saturating count of stalled valid cycles
module cpu_load_scoreboard #(
   parameter int NUM_REGS    = 32,
   parameter int REG_W       = 5,
   parameter int MAX_PENDING = 4,
   parameter int PERF_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_ra,
   input  logic [REG_W-1:0]  id_rb,
   input  logic              id_ra_used,
   input  logic              id_rb_used,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_writeback,
   input  logic              id_is_load,
   input  logic              flush,
   input  logic              ld_done,
   input  logic [REG_W-1:0]  ld_rd,
   input  logic              drain_req,
   output logic              stall_id,
   output logic              id_fire,
   output logic [3:0]        pending_cnt,
   output logic              drained,
   output logic              err_spurious,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_DRAIN   = 2'd1;
   localparam logic [1:0] ST_DRAINED = 2'd2;

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_nxt;
   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic                raw;
   logic                waw;
   logic                full;
   logic                issue_set;
   logic                ld_hit;
   logic                ret_clr;

   // Hazards look only at registered pending bits, so a register cleared by
   // ld_done this cycle still stalls; its value comes from the writeback bypass
   // on the following cycle.
   assign raw = (id_ra_used && (id_ra != '0) && pending[id_ra]) ||
                (id_rb_used && (id_rb != '0) && pending[id_rb]);
   assign waw  = id_writeback && (id_rd != '0) && pending[id_rd];
   assign full = id_is_load && (pending_cnt == 4'(MAX_PENDING));

   assign stall_id = id_valid && (raw || waw || full || (state != ST_RUN));
   assign id_fire  = id_valid && !stall_id && !flush;

   // Loads to r0 or without writeback owe nothing, so they are not tracked.
   assign issue_set = id_fire && id_is_load && id_writeback && (id_rd != '0);
   assign ld_hit    = pending[ld_rd];
   assign ret_clr   = ld_done && ld_hit;

   assign drained = (state == ST_DRAINED);

   // A return and an issue never target the same register in one cycle while
   // it is pending (WAW stalls that issue), so clear-then-set is safe.
   always_comb begin
      pending_nxt = pending;
      if (ret_clr) begin
         pending_nxt[ld_rd] = 1'b0;
      end
      if (issue_set) begin
         pending_nxt[id_rd] = 1'b1;
      end
   end

   // Dropping drain_req takes priority over completing the drain.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (drain_req) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_req)              state_nxt = ST_RUN;
            else if (pending_cnt == '0) state_nxt = ST_DRAINED;
         end
         ST_DRAINED: begin
            if (!drain_req) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending      <= '0;
         pending_cnt  <= '0;
         state        <= ST_RUN;
         err_spurious <= 1'b0;
         stall_cycles <= '0;
      end else begin
         pending     <= pending_nxt;
         pending_cnt <= pending_cnt + {3'b000, issue_set} - {3'b000, ret_clr};
         state       <= state_nxt;
         if (ld_done && !ld_hit) begin
            err_spurious <= 1'b1;
         end
         if (id_valid && stall_id && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
         end
      end
   end

endmodule
